// File: rtl/button_debouncer.sv
// button_debouncer
//   Two-flop synchroniser followed by a stability-counter FSM that turns a
//   bouncy push-button pin into a clean level plus one-cycle press/release
//   strobes. All outputs are registered.
//   Optional auto-repeat is built only when BUTTON_DEBOUNCE_REPEAT_EN is
//   defined; otherwise button_repeat is tied low.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter bit ACTIVE_HIGH          = 1'b1,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic button,
    output logic button_level,
    output logic button_press,
    output logic button_release,
    output logic button_repeat
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1, so it can never wrap.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations that would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_params
        $error("button_debouncer: cycle-count parameters must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_n;
    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic             accept_press;
    logic             accept_release;

    // Normalise polarity before the synchroniser so downstream 1 = pressed.
    assign btn_n = ACTIVE_HIGH ? button : ~button;

    // A new level is accepted on the cycle the counter has seen it long enough.
    assign accept_press   = (state_q == PRESS_WAIT)   &&  s2_q && (cnt_q == CNT_LAST);
    assign accept_release = (state_q == RELEASE_WAIT) && !s2_q && (cnt_q == CNT_LAST);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_n;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM: any reversal during a wait state returns to the stable state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (accept_press) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (accept_release) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_active;

    // Repeat timing survives release bounce, so it runs in both held states.
    assign rpt_active = (state_q == HELD) || (state_q == RELEASE_WAIT);

    // Down-counter to the next repeat strobe; loaded on press, cleared on release.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rpt_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (accept_press) begin
                rpt_cnt_q <= RPT_FIRST;
            end else if (accept_release || !rpt_active) begin
                rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == '0) begin
                repeat_q  <= 1'b1;
                rpt_cnt_q <= RPT_NEXT;
            end else begin
                rpt_cnt_q <= rpt_cnt_q - 1'b1;
            end
        end
    end
`else
    assign repeat_q = 1'b0;
`endif

    assign button_level   = level_q;
    assign button_press   = press_q;
    assign button_release = release_q;
    assign button_repeat  = repeat_q;

endmodule
